iram_boot_loader: RTL and testbench
===================================

Name: iram_boot_loader

Overview:
- Writable 128x16 instruction memory with a byte-stream boot loader; it replaces the reset-initialised instruction ROM.
- The loader receives a framed program over a valid/ready byte interface and writes 16-bit instructions into memory.
- The CPU fetch port reads the same memory.
- CPU_HOLD keeps the processor stalled until a program loads and checks clean.

Parameters:
- DEPTH, 128, number of 16-bit instruction entries (word address width 7).
- MAX_COUNT, 128, largest legal instruction count in a frame header.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RESET  input  1  synchronous, active-high reset.
- ADDR  input  8  CPU fetch byte address; word index = ADDR[7:1], ADDR[0] ignored.
- Q  output  16  instruction at mem[ADDR[7:1]], combinational read.
- RX_DATA  input  8  incoming loader byte.
- RX_VALID  input  1  RX_DATA valid.
- RX_READY  output  1  loader can accept a byte; transfer occurs on a posedge with RX_VALID && RX_READY.
- BUSY  output  1  frame in progress.
- DONE  output  1  program loaded and checksum matched (sticky).
- ERR  output  1  frame rejected (sticky).
- CPU_HOLD  output  1  stall request to the CPU; 1 until DONE.

Behaviour:
- Reset (synchronous, while RESET=1 at posedge):
  - All DEPTH entries are cleared to 16'h0000 (NOP).
  - State goes to IDLE; word pointer WP=0, count N=0, running checksum CS=0.
  - Outputs: BUSY=0, DONE=0, ERR=0, CPU_HOLD=1, RX_READY=0 during reset.
- RX_READY is 1 in IDLE, HI, LO and CHK, and 0 in DONE_S and ERR_S.
- Frame format: count byte N, then N instructions as high byte then low byte, then one checksum byte. The checksum is the XOR of every preceding frame byte, including N.
- Every accepted byte except the checksum is XORed into CS.
- FSM:
  - IDLE: accept byte, then N<=byte, CS<=byte.
    - If byte==0 or byte>MAX_COUNT, go to ERR_S.
    - Otherwise go to HI with BUSY=1.
  - HI: accept byte, latch as HB, go to LO.
  - LO: accept byte; on the same edge write mem[WP] <= {HB, byte} and WP<=WP+1.
    - If WP+1==N, go to CHK; otherwise go to HI.
  - CHK: accept byte.
    - If byte==CS, go to DONE_S: DONE=1, BUSY=0, CPU_HOLD=0.
    - Otherwise go to ERR_S: ERR=1, BUSY=0, CPU_HOLD=1.
  - DONE_S, ERR_S: terminal until RESET; RX_VALID is ignored.
- No accept in a cycle means no state change; RX_VALID gaps of any length are legal.
- WP is 8 bits, so N=128 completes with WP==128. The write to mem[127] is the last write; there is no wrap-around.
- Entries at index >= N keep 0.
- On a bad checksum, written words are retained; ERR does not clear memory.
- Q is combinational at all times, including mid-load. A read of the entry being written returns the old value until the edge.
- RESET asserted mid-frame aborts the frame, clears memory, and returns to IDLE on that edge.
- Outputs are registered; DONE/ERR/CPU_HOLD change on the edge that accepts the final byte.
- Exactly one of DONE and ERR can ever be 1.

Test Plan:
- Good frame: bytes 02,F0,01,51,7F,DD with continuous valid. Required response:
  - After the last byte, DONE=1, CPU_HOLD=0, BUSY=0, ERR=0, RX_READY=0.
  - ADDR=00 gives Q=F001; ADDR=02 and ADDR=03 give Q=517F; ADDR=04 gives Q=0000.
- Bad checksum: the same frame ending in 00. Required response: ERR=1, DONE=0, CPU_HOLD=1, and ADDR=00 still reads Q=F001.
- Illegal counts:
  - Header 81: ERR=1 on the accepting edge, no memory writes, RX_READY=0 afterwards.
  - Header 00: same response as header 81.
- Back-pressure/gaps: good frame with RX_VALID low for 3 cycles between every byte. Required response: identical final memory and DONE to the first scenario, and BUSY=1 throughout the gaps.
- Reset mid-load: send 02,F0,01, then pulse RESET for one cycle. Required response:
  - mem[0]=0000, IDLE with RX_READY=1, BUSY=0, CPU_HOLD=1.
  - A following full good frame then loads correctly.
- Full depth: N=80 (128 words, word i = {i, ~i}) with the correct checksum. Required response:
  - ADDR=FE gives Q=7F80; DONE=1.
  - Extra bytes after the checksum are not accepted and memory is unchanged.

Source files
------------

// File: rtl/iram_boot_loader.sv
// Writable 128x16 instruction RAM filled by a framed byte-stream loader.
// The CPU fetch port reads the same array combinationally; CPU_HOLD stalls it until a clean load.
module iram_boot_loader #(
  parameter int DEPTH     = 128,
  parameter int MAX_COUNT = 128
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  ADDR,
  output logic [15:0] Q,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        CPU_HOLD
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] MAXC = 8'(MAX_COUNT);

  typedef enum logic [2:0] {IDLE, HI, LO, CHK, DONE_S, ERR_S} state_t;

  state_t      state_q, state_d;
  logic [7:0]  wp_q, wp_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  cs_q, cs_d;
  logic [7:0]  hb_q, hb_d;
  logic        we;
  logic        rdy;
  logic        accept;
  logic [15:0] mem_q [DEPTH];
  logic        unused_addr0;

  assign unused_addr0 = ADDR[0];
  assign Q            = mem_q[ADDR[AW:1]];

  assign rdy      = (state_q == IDLE) || (state_q == HI) || (state_q == LO) || (state_q == CHK);
  assign accept   = RX_VALID && rdy;
  assign RX_READY = rdy && !RESET;
  assign BUSY     = (state_q == HI) || (state_q == LO) || (state_q == CHK);
  assign DONE     = (state_q == DONE_S);
  assign ERR      = (state_q == ERR_S);
  assign CPU_HOLD = (state_q != DONE_S);

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    n_d     = n_q;
    cs_d    = cs_q;
    hb_d    = hb_q;
    we      = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          n_d     = RX_DATA;
          cs_d    = RX_DATA;
          state_d = (RX_DATA == 8'd0 || RX_DATA > MAXC) ? ERR_S : HI;
        end
        HI: begin
          hb_d    = RX_DATA;
          cs_d    = cs_q ^ RX_DATA;
          state_d = LO;
        end
        LO: begin
          we      = 1'b1;
          wp_d    = wp_q + 8'd1;
          cs_d    = cs_q ^ RX_DATA;
          state_d = (wp_q + 8'd1 == n_q) ? CHK : HI;
        end
        CHK:     state_d = (RX_DATA == cs_q) ? DONE_S : ERR_S;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      wp_q    <= '0;
      n_q     <= '0;
      cs_q    <= '0;
      hb_q    <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      n_q     <= n_d;
      cs_q    <= cs_d;
      hb_q    <= hb_d;
    end
  end

  // Reset clears every entry to NOP so unloaded addresses fetch harmlessly.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wp_q[AW-1:0]] <= {hb_q, RX_DATA};
    end
  end

endmodule

// File: tb/tb_iram_boot_loader.sv
// Scoreboard bench for iram_boot_loader: stimulus queues expected values, a negedge monitor checks them.
module tb_iram_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [15:0] q;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready, busy, done, err, cpu_hold;

  iram_boot_loader dut (
    .CLK(clk), .RESET(rst), .ADDR(addr), .Q(q),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready),
    .BUSY(busy), .DONE(done), .ERR(err), .CPU_HOLD(cpu_hold)
  );

  always #5 clk = ~clk;

  // status vector {RX_READY, BUSY, DONE, ERR, CPU_HOLD}
  localparam logic [15:0] ST_RST  = 16'b00001;
  localparam logic [15:0] ST_IDLE = 16'b10001;
  localparam logic [15:0] ST_BUSY = 16'b11001;
  localparam logic [15:0] ST_DONE = 16'b00100;
  localparam logic [15:0] ST_ERR  = 16'b00011;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      item_t e;
      logic [15:0] act;
      e = sb.pop_front();
      act = (e.sel == 1) ? {11'b0, rx_ready, busy, done, err, cpu_hold} : q;
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic chk_st(input logic [15:0] exp, input string name);
    item_t e;
    e.name = name; e.sel = 1; e.exp = exp;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic chk_q(input logic [7:0] a, input logic [15:0] exp, input string name);
    item_t e;
    addr = a;
    e.name = name; e.sel = 0; e.exp = exp;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic chk_gap);
    int waited;
    rx_data  = b;
    rx_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 20) begin
        checks++;
        errors++;
        $display("FAIL handshake timeout: byte %h not accepted, expected accept", b);
        break;
      end
    end
    rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (chk_gap) chk_st(ST_BUSY, "busy_in_gap");
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic good_frame(input int gap);
    logic [7:0] fr [6];
    fr[0] = 8'h02; fr[1] = 8'hF0; fr[2] = 8'h01;
    fr[3] = 8'h51; fr[4] = 8'h7F; fr[5] = 8'hDD;
    for (int i = 0; i < 6; i++) send_byte(fr[i], (i < 5) ? gap : 0, i < 5);
  endtask

  task automatic check_good(input string tag);
    chk_st(ST_DONE, {tag, "_status"});
    chk_q(8'h00, 16'hF001, {tag, "_q00"});
    chk_q(8'h02, 16'h517F, {tag, "_q02"});
    chk_q(8'h03, 16'h517F, {tag, "_q03"});
    chk_q(8'h04, 16'h0000, {tag, "_q04"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; addr = 8'h00; rx_data = 8'h00; rx_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sb.push_back('{"reset_status", 1, ST_RST});
    sb.push_back('{"reset_q00", 0, 16'h0000});
    @(posedge clk); #1;
    rst = 1'b0;
    chk_st(ST_IDLE, "idle_after_reset");

    // good frame, continuous valid
    good_frame(0);
    check_good("good");

    // bad checksum keeps written words
    do_reset();
    send_byte(8'h02, 0, 0); send_byte(8'hF0, 0, 0); send_byte(8'h01, 0, 0);
    send_byte(8'h51, 0, 0); send_byte(8'h7F, 0, 0); send_byte(8'h00, 0, 0);
    chk_st(ST_ERR, "badcs_status");
    chk_q(8'h00, 16'hF001, "badcs_q00");
    chk_q(8'h02, 16'h517F, "badcs_q02");

    // illegal header 81
    do_reset();
    send_byte(8'h81, 0, 0);
    chk_st(ST_ERR, "hdr81_status");
    chk_q(8'h00, 16'h0000, "hdr81_q00");

    // illegal header 00
    do_reset();
    send_byte(8'h00, 0, 0);
    chk_st(ST_ERR, "hdr00_status");
    chk_q(8'h00, 16'h0000, "hdr00_q00");

    // gaps of 3 cycles between bytes, BUSY held throughout
    do_reset();
    good_frame(3);
    check_good("gap");

    // reset mid-load aborts and clears
    do_reset();
    send_byte(8'h02, 0, 0); send_byte(8'hF0, 0, 0); send_byte(8'h01, 0, 0);
    chk_q(8'h00, 16'hF001, "midload_written");
    do_reset();
    chk_st(ST_IDLE, "midreset_status");
    chk_q(8'h00, 16'h0000, "midreset_q00");
    good_frame(0);
    check_good("reload");

    // full depth: 128 words {i, ~i}; payload XOR cancels to 00, checksum = 80
    do_reset();
    send_byte(8'h80, 0, 0);
    for (int i = 0; i < 128; i++) begin
      logic [7:0] hb;
      hb = 8'(i);
      send_byte(hb, 0, 0);
      send_byte(~hb, 0, 0);
    end
    send_byte(8'h80, 0, 0);
    chk_st(ST_DONE, "full_status");
    chk_q(8'hFE, 16'h7F80, "full_qFE");
    chk_q(8'h00, 16'h00FF, "full_q00");
    chk_q(8'h80, 16'h40BF, "full_q80");
    rx_data = 8'h55; rx_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk_st(ST_DONE, "extra_status");
    chk_q(8'hFE, 16'h7F80, "extra_qFE");
    chk_q(8'h00, 16'h00FF, "extra_q00");
    rx_valid = 1'b0;

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
